// File: rtl/blake2s_io_host.sv
// blake2s_io_host
//   Host-side sequencer that drives a BLAKE2s core over an 8-bit command bus.
//   For one message it sends the CONF bytes (kk, nn, ll[7:0]..ll[63:56]) and
//   the START command. It then streams the message bytes and zero-pads them to
//   a whole number of 64-byte blocks. Finally it waits for the digest and
//   forwards it as a byte stream.
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start_i, kk_i, nn_i, ll_i   operation request and its parameters
//   msg_v_i, msg_i, msg_ready_o message byte input (valid/ready)
//   valid_o, cmd_o, data_o      byte bus toward the hash core
//   hash_finished_i, hash_i     digest bytes returned by the core
//   digest_v_o/_o/_last_o       forwarded digest stream (no backpressure)
//   busy_o, done_o, err_o       status: active, completion pulse, error pulse
module blake2s_io_host #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int NN_MAX      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  kk_i,
  input  logic [7:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        msg_v_i,
  input  logic [7:0]  msg_i,
  output logic        msg_ready_o,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  input  logic        hash_finished_i,
  input  logic [7:0]  hash_i,
  output logic        digest_v_o,
  output logic [7:0]  digest_o,
  output logic        digest_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT_CYC);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
  localparam logic [7:0]     NN_MAX_B  = 8'(NN_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_START, S_DATA, S_PAD, S_WAIT, S_READ
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      kk_reg, nn_reg;
  logic [63:0]     ll_reg;
  logic [3:0]      conf_cnt_reg;
  logic [5:0]      idx_reg;
  logic [63:0]     byte_cnt_reg;
  logic [WCW-1:0]  wait_cnt_reg;
  logic [7:0]      rd_cnt_reg;
  logic            done_reg;

  logic [7:0] nn_eff;
  logic       accept, last_msg, digest_byte, last_digest;
  logic [7:0] conf_byte;
  logic [7:0] ll_byte [8];

  // Little-endian byte view of the latched message length.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ll_byte
      assign ll_byte[gi] = ll_reg[8*gi +: 8];
    end
  endgenerate

  // Number of digest bytes to forward: nn clamped to NN_MAX, and 0 means 1.
  always_comb begin
    nn_eff = nn_reg;
    if (nn_reg == 8'd0)
      nn_eff = 8'd1;
    else if (nn_reg > NN_MAX_B)
      nn_eff = NN_MAX_B;
  end

  always_comb begin
    conf_byte = ll_byte[3'(conf_cnt_reg - 4'd2)];
    if (conf_cnt_reg == 4'd0)
      conf_byte = kk_reg;
    else if (conf_cnt_reg == 4'd1)
      conf_byte = nn_reg;
  end

  assign accept      = (state_reg == S_DATA) && msg_v_i;
  assign last_msg    = accept && ((byte_cnt_reg + 64'd1) == ll_reg);
  // Byte 0 of the digest is taken in the same WAIT cycle in which
  // hash_finished_i first rises, so WAIT and READ both forward bytes.
  assign digest_byte = ((state_reg == S_WAIT) || (state_reg == S_READ)) && hash_finished_i;
  assign last_digest = digest_byte && ((rd_cnt_reg + 8'd1) == nn_eff);

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i) state_next = S_CONF;
      S_CONF:  if (conf_cnt_reg == 4'd9) state_next = S_START;
      // An empty message goes straight to padding: one all-zero block.
      S_START: state_next = (ll_reg == 64'd0) ? S_PAD : S_DATA;
      // If the last byte fills the block (index about to wrap), no padding is needed.
      S_DATA:  if (last_msg) state_next = (idx_reg == 6'd63) ? S_WAIT : S_PAD;
      S_PAD:   if (idx_reg == 6'd63) state_next = S_WAIT;
      S_WAIT: begin
        if (hash_finished_i)
          state_next = last_digest ? S_IDLE : S_READ;
        else if (wait_cnt_reg == TIMEOUT_W)
          state_next = S_IDLE;
      end
      S_READ:  if (!hash_finished_i || last_digest) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      kk_reg       <= 8'd0;
      nn_reg       <= 8'd0;
      ll_reg       <= 64'd0;
      conf_cnt_reg <= 4'd0;
      idx_reg      <= 6'd0;
      byte_cnt_reg <= 64'd0;
      wait_cnt_reg <= '0;
      rd_cnt_reg   <= 8'd0;
      done_reg     <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == S_WAIT) ? wait_cnt_reg + WAIT_ONE : '0;
      done_reg     <= last_digest;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            kk_reg <= kk_i;
            nn_reg <= nn_i;
            ll_reg <= ll_i;
          end
          conf_cnt_reg <= 4'd0;
          idx_reg      <= 6'd0;
          byte_cnt_reg <= 64'd0;
          rd_cnt_reg   <= 8'd0;
        end
        S_CONF: conf_cnt_reg <= conf_cnt_reg + 4'd1;
        S_DATA: begin
          if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 64'd1;
            idx_reg      <= idx_reg + 6'd1;
          end
        end
        S_PAD:  idx_reg <= idx_reg + 6'd1;
        S_WAIT, S_READ: if (digest_byte) rd_cnt_reg <= rd_cnt_reg + 8'd1;
        default: ;
      endcase
    end
  end

  // Output logic; held at zero while reset is asserted.
  always_comb begin
    msg_ready_o   = 1'b0;
    valid_o       = 1'b0;
    cmd_o         = 2'd0;
    data_o        = 8'd0;
    digest_v_o    = 1'b0;
    digest_o      = 8'd0;
    digest_last_o = 1'b0;
    busy_o        = (state_reg != S_IDLE);
    done_o        = done_reg;
    err_o         = 1'b0;
    case (state_reg)
      S_CONF: begin
        valid_o = 1'b1;
        data_o  = conf_byte;
      end
      S_START: begin
        valid_o = 1'b1;
        cmd_o   = 2'd1;
      end
      S_DATA: begin
        msg_ready_o = 1'b1;
        if (msg_v_i) begin
          valid_o = 1'b1;
          cmd_o   = 2'd2;
          data_o  = msg_i;
        end
      end
      S_PAD: begin
        valid_o = 1'b1;
        cmd_o   = 2'd2;
      end
      S_WAIT, S_READ: begin
        if (hash_finished_i) begin
          digest_v_o    = 1'b1;
          digest_o      = hash_i;
          digest_last_o = last_digest;
        end else if (state_reg == S_READ || wait_cnt_reg == TIMEOUT_W) begin
          err_o = 1'b1;
        end
      end
      default: ;
    endcase
    if (reset) begin
      msg_ready_o   = 1'b0;
      valid_o       = 1'b0;
      cmd_o         = 2'd0;
      data_o        = 8'd0;
      digest_v_o    = 1'b0;
      digest_o      = 8'd0;
      digest_last_o = 1'b0;
      busy_o        = 1'b0;
      done_o        = 1'b0;
      err_o         = 1'b0;
    end
  end

endmodule

// File: tb/tb_blake2s_io_host.sv
// tb_blake2s_io_host
//   Directed bench for blake2s_io_host. Each message run records every bus
//   strobe and digest byte, then compares them against values derived from
//   the run parameters.
module tb_blake2s_io_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  kk_i, nn_i;
  logic [63:0] ll_i;
  logic        msg_v_i;
  logic [7:0]  msg_i;
  logic        msg_ready_o;
  logic        valid_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o;
  logic        hash_finished_i;
  logic [7:0]  hash_i;
  logic        digest_v_o;
  logic [7:0]  digest_o;
  logic        digest_last_o;
  logic        busy_o, done_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] msg_mem [0:255];
  int s_cmd[$], s_data[$], s_cyc[$];
  int d_data[$], d_last[$], d_cyc[$];

  always #5 clk = ~clk;

  blake2s_io_host #(.TIMEOUT_CYC(16), .NN_MAX(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .ll_i(ll_i), .msg_v_i(msg_v_i), .msg_i(msg_i), .msg_ready_o(msg_ready_o),
    .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o),
    .hash_finished_i(hash_finished_i), .hash_i(hash_i),
    .digest_v_o(digest_v_o), .digest_o(digest_o), .digest_last_o(digest_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {msg_ready_o, valid_o, cmd_o, data_o, digest_v_o, digest_o,
                digest_last_o, busy_o, done_o, err_o}, 64'd0);
  endtask

  // One complete operation. gap: message valid only on even cycles.
  // hdelay: WAIT cycles before the digest appears. short_n: digest bytes
  // withheld (hash_finished_i drops early). no_hash: digest never appears.
  // busy_start: pulse start_i again during CONF.
  task automatic run_msg(input int kk, input int nn, input int ll, input int gap,
                         input int hdelay, input int short_n, input bit no_hash,
                         input bit busy_start);
    int cyc, sent, exp_total, nd, wait_cyc, done_cyc, err_cyc;
    int n_done, n_errp, max_ready, hcnt, nn_eff, h_limit, sp;
    bit fin;
    logic [7:0] expd;
    s_cmd.delete(); s_data.delete(); s_cyc.delete();
    d_data.delete(); d_last.delete(); d_cyc.delete();
    cyc = 0; sent = 0; nd = 0; wait_cyc = -1; done_cyc = -1; err_cyc = -1;
    n_done = 0; n_errp = 0; max_ready = 0; hcnt = 0; fin = 1'b0;
    nn_eff    = (nn == 0) ? 1 : ((nn > 32) ? 32 : nn);
    h_limit   = nn_eff - short_n;
    exp_total = (ll == 0) ? 64 : 64 * ((ll + 63) / 64);

    @(negedge clk);
    start_i = 1'b1; kk_i = 8'(kk); nn_i = 8'(nn); ll_i = 64'(ll);
    @(negedge clk);
    start_i = 1'b0; kk_i = 8'hEE; nn_i = 8'hEE; ll_i = {8{8'hEE}};

    while (cyc < 3000 && !fin) begin
      start_i = busy_start && (cyc == 3);
      msg_v_i = (sent < ll) && (gap == 0 || (cyc % 2) == 0);
      msg_i   = msg_mem[sent[7:0]];
      if (!no_hash && wait_cyc >= 0 && cyc >= wait_cyc + hdelay && hcnt < h_limit) begin
        hash_finished_i = 1'b1;
        hash_i = 8'hA0 + 8'(hcnt);
      end else begin
        hash_finished_i = 1'b0;
        hash_i = 8'h5A;
      end
      #1;
      if (msg_ready_o) max_ready = 1;
      if (valid_o) begin
        s_cmd.push_back(int'(cmd_o)); s_data.push_back(int'(data_o)); s_cyc.push_back(cyc);
        if (cmd_o == 2'd2) begin
          nd++;
          if (nd == exp_total) wait_cyc = cyc + 1;
        end
      end
      if (msg_v_i && msg_ready_o) sent++;
      if (hash_finished_i) hcnt++;
      if (digest_v_o) begin
        d_data.push_back(int'(digest_o)); d_last.push_back(int'(digest_last_o)); d_cyc.push_back(cyc);
      end
      if (done_o) begin n_done++; done_cyc = cyc; fin = 1'b1; end
      if (err_o)  begin n_errp++; err_cyc = cyc; fin = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; msg_v_i = 1'b0; hash_finished_i = 1'b0;
    if (!fin) check("cycle_budget", 0, 1);
    #1;
    check("idle_after", busy_o, 1'b0);

    check("n_strobes", s_cmd.size(), 11 + exp_total);
    if (s_cmd.size() == 11 + exp_total) begin
      for (int i = 0; i < 10; i++) begin
        expd = (i == 0) ? 8'(kk) : (i == 1) ? 8'(nn) : 8'(64'(ll) >> (8 * (i - 2)));
        check("conf_byte", {s_cmd[i][1:0], s_data[i][7:0]}, {2'd0, expd});
        check("conf_cyc", s_cyc[i], i);
      end
      check("start_byte", {s_cmd[10][1:0], s_data[10][7:0]}, {2'd1, 8'd0});
      check("start_cyc", s_cyc[10], 10);
      for (int i = 0; i < exp_total; i++) begin
        expd = (i < ll) ? msg_mem[i] : 8'd0;
        check("data_byte", {s_cmd[11+i][1:0], s_data[11+i][7:0]}, {2'd2, expd});
        if (i > 0) begin
          sp = (i < ll && gap != 0) ? 2 : 1;
          check("data_spacing", s_cyc[11+i] - s_cyc[10+i], sp);
        end
      end
    end
    if (ll == 0) check("ready_never", max_ready, 0);

    check("n_digest", d_data.size(), no_hash ? 0 : h_limit);
    if (!no_hash && d_data.size() == h_limit) begin
      for (int k = 0; k < h_limit; k++) begin
        check("digest_byte", d_data[k], 8'hA0 + k);
        check("digest_last", d_last[k], (k == nn_eff - 1) ? 1 : 0);
        check("digest_cyc", d_cyc[k], wait_cyc + hdelay + k);
      end
    end
    if (no_hash) begin
      check("timeout_cyc", err_cyc, wait_cyc + 16);
      check("timeout_no_done", n_done, 0);
    end else if (short_n > 0) begin
      check("drop_err_cyc", err_cyc, wait_cyc + hdelay + h_limit);
      check("drop_no_done", n_done, 0);
    end else begin
      check("done_cyc", done_cyc, wait_cyc + hdelay + nn_eff);
      check("n_done", n_done, 1);
      check("no_err", n_errp, 0);
    end
    $display("run kk=%0d nn=%0d ll=%0d strobes=%0d digest=%0d done=%0d err=%0d",
             kk, nn, ll, s_cmd.size(), d_data.size(), n_done, n_errp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) msg_mem[i] = 8'h61 + 8'(i);
    reset = 1'b1; start_i = 1'b0; kk_i = 8'd0; nn_i = 8'd0; ll_i = 64'd0;
    msg_v_i = 1'b0; msg_i = 8'd0; hash_finished_i = 1'b0; hash_i = 8'd0;
    repeat (3) @(negedge clk);
    #1 check_idle("reset_during");
    @(negedge clk);
    reset = 1'b0;
    #1 check_idle("reset_after");

    run_msg(0, 32, 3, 0, 2, 0, 1'b0, 1'b1);   // "abc", start while busy ignored
    run_msg(0, 32, 0, 0, 0, 0, 1'b0, 1'b0);   // empty message
    run_msg(0, 16, 64, 0, 1, 0, 1'b0, 1'b0);  // exact block, no pad
    run_msg(0, 0, 65, 0, 0, 0, 1'b0, 1'b0);   // 65 + 63 pad, nn=0 -> 1 byte
    run_msg(8, 40, 10, 1, 3, 0, 1'b0, 1'b0);  // gapped input, nn clamped to 32
    run_msg(0, 32, 5, 0, 0, 0, 1'b1, 1'b0);   // timeout
    run_msg(0, 8, 2, 0, 1, 3, 1'b0, 1'b0);    // digest drops early

    // Reset in the middle of DATA
    @(negedge clk);
    start_i = 1'b1; kk_i = 8'd0; nn_i = 8'd32; ll_i = 64'd20;
    @(negedge clk);
    start_i = 1'b0;
    msg_v_i = 1'b1; msg_i = 8'h11;
    repeat (14) @(negedge clk);
    #1 check("mid_data_busy", {busy_o, msg_ready_o}, 2'b11);
    reset = 1'b1;
    #1 check_idle("mid_reset_during");
    @(negedge clk);
    reset = 1'b0;
    #1 check_idle("mid_reset_after");
    msg_v_i = 1'b0;
    run_msg(0, 32, 3, 0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/blake2s_io_host.md
BLAKE2S_IO_HOST -- requirements
Module: blake2s_io_host

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: maximum cycles in WAIT for hash_finished_i before error.
REQ-002 Parameter NN_MAX, default 32: maximum digest bytes.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  one-cycle request to hash one message; ignored unless busy_o=0.
REQ-007 kk_i, nn_i  in  8 each  key length, digest length; sampled when start_i accepted.
REQ-008 ll_i  in  64  message byte count; sampled when start_i accepted.
REQ-009 msg_v_i  in  1  message byte valid.
REQ-010 msg_i  in  8  message byte.
REQ-011 msg_ready_o  out  1  byte accepted when msg_v_i & msg_ready_o.
REQ-012 valid_o  out  1  byte-bus strobe to hash core interface.
REQ-013 cmd_o  out  2  command: 0 CONF, 1 START, 2 DATA, 3 reserved (never driven).
REQ-014 data_o  out  8  byte-bus payload.
REQ-015 hash_finished_i  in  1  high while digest bytes are presented.
REQ-016 hash_i  in  8  digest byte, byte 0 on first cycle hash_finished_i is high.
REQ-017 digest_v_o, digest_o[7:0], digest_last_o  out  1/8/1  digest byte stream, no backpressure.
REQ-018 busy_o, done_o, err_o  out  1 each  operation active; one-cycle completion pulse; one-cycle timeout pulse.

Function
REQ-019 States: IDLE, CONF, START, DATA, PAD, WAIT, READ; one state per cycle progression, no skipped cycles.
REQ-020 IDLE: busy_o=0; start_i=1 latches kk/nn/ll, -> CONF next cycle.
REQ-021 CONF: 10 consecutive cycles valid_o=1, cmd_o=0, data_o = kk, nn, ll bytes 0..7 (little-endian); -> START.
REQ-022 START: one cycle valid_o=1, cmd_o=1, data_o=0; -> DATA.
REQ-023 DATA: msg_ready_o=1; each accepted byte drives valid_o=1, cmd_o=2, data_o=msg_i combinationally in same cycle; valid_o=0 when msg_v_i=0.
REQ-024 6-bit block index counter increments per DATA/PAD byte, wraps 63->0; 64-bit byte counter counts accepted message bytes.
REQ-025 When byte counter reaches ll: if index=0 and ll>0 -> WAIT; else -> PAD.
REQ-026 PAD: msg_ready_o=0; valid_o=1, cmd_o=2, data_o=0 each cycle until index wraps to 0; -> WAIT.
REQ-027 ll=0: DATA performs no accepts, PAD emits exactly 64 zero bytes.
REQ-028 Total DATA+PAD bytes = 64*max(1, ceil(ll/64)).
REQ-029 WAIT: valid_o=0; cycle counter from 0; hash_finished_i=1 -> READ same-cycle capture of byte 0; counter reaching TIMEOUT_CYC -> err_o=1 one cycle, -> IDLE.
REQ-030 READ: forward hash_i to digest_o with digest_v_o=1 for min(nn,NN_MAX) bytes (nn=0 treated as 1); digest_last_o=1 on final byte; done_o=1 on the cycle after final byte, -> IDLE.
REQ-031 hash_finished_i dropping before nn bytes: err_o pulse, -> IDLE, done_o not asserted.
REQ-032 start_i while busy_o=1: ignored, no state change.
REQ-033 msg_ready_o=0 outside DATA; msg bytes presented outside DATA are not consumed.

Reset
REQ-034 reset=1 at any clock edge, including mid-operation: state IDLE, all counters 0, latched kk/nn/ll 0.
REQ-035 Output values during/after reset: valid_o=0, cmd_o=0, data_o=0, msg_ready_o=0, digest_v_o=0, digest_o=0, digest_last_o=0, busy_o=0, done_o=0, err_o=0.

Verification
REQ-036 kk=0, nn=32, ll=3 "abc" -> CONF bytes 00,20,03,00x7; START; 61,62,63 then 61 zero pad bytes; 32 digest bytes, last flagged, done_o pulse.
REQ-037 ll=0, nn=32 -> exactly 64 DATA bytes all 00, msg_ready_o never 1.
REQ-038 ll=64 then ll=65 -> 64 DATA bytes with no PAD; 65 bytes + 63 pad = 128 DATA strobes.
REQ-039 msg_v_i toggling every other cycle, ll=10 -> valid_o gaps mirror input gaps, byte order preserved.
REQ-040 hash_finished_i never asserted, TIMEOUT_CYC=16 -> err_o pulse 16 cycles after WAIT entry, back to IDLE, no done_o.
REQ-041 reset asserted mid-DATA -> next cycle all outputs 0, IDLE; fresh start_i completes normally.
